// File: rtl/ascii_to_scan_sequencer.sv
// ascii_to_scan_sequencer: encodes one ASCII character into the PS/2 Set-2
// make/break byte stream for that keystroke, wrapping shifted characters in
// a left-Shift make/break pair. Byte stream is valid/ready with a last flag.
module ascii_to_scan_sequencer #(
  parameter int          GAP_CYCLES = 0,
  parameter logic [7:0]  SHIFT_CODE = 8'h12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ascii_code,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  input  logic       scan_ready,
  output logic       scan_last,
  output logic       busy,
  output logic       unsupported
);

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  // sup/shift flags plus the key's make code
  typedef struct packed {
    logic       sup;
    logic       shift;
    logic [7:0] key;
  } map_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] GAP_LAST   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  // Make codes for the letter keys, indexed a..z
  function automatic logic [7:0] letter_key(input logic [4:0] i);
    case (i)
      5'd0:  letter_key = 8'h1C;  5'd1:  letter_key = 8'h32;
      5'd2:  letter_key = 8'h21;  5'd3:  letter_key = 8'h23;
      5'd4:  letter_key = 8'h24;  5'd5:  letter_key = 8'h2B;
      5'd6:  letter_key = 8'h34;  5'd7:  letter_key = 8'h33;
      5'd8:  letter_key = 8'h43;  5'd9:  letter_key = 8'h3B;
      5'd10: letter_key = 8'h42;  5'd11: letter_key = 8'h4B;
      5'd12: letter_key = 8'h3A;  5'd13: letter_key = 8'h31;
      5'd14: letter_key = 8'h44;  5'd15: letter_key = 8'h4D;
      5'd16: letter_key = 8'h15;  5'd17: letter_key = 8'h2D;
      5'd18: letter_key = 8'h1B;  5'd19: letter_key = 8'h2C;
      5'd20: letter_key = 8'h3C;  5'd21: letter_key = 8'h2A;
      5'd22: letter_key = 8'h1D;  5'd23: letter_key = 8'h22;
      5'd24: letter_key = 8'h35;  5'd25: letter_key = 8'h1A;
      default: letter_key = 8'h00;
    endcase
  endfunction

  // Full character map; {2'b10,K} = plain key K, {2'b11,K} = Shift + K
  function automatic map_t lookup(input logic [7:0] c);
    map_t m;
    m = '0;
    if (c >= 8'h61 && c <= 8'h7A) begin
      m = {2'b10, letter_key(5'(c - 8'h61))};
    end else if (c >= 8'h41 && c <= 8'h5A) begin
      m = {2'b11, letter_key(5'(c - 8'h41))};
    end else begin
      case (c)
        // digits
        8'h30: m = {2'b10, 8'h45};  8'h31: m = {2'b10, 8'h16};
        8'h32: m = {2'b10, 8'h1E};  8'h33: m = {2'b10, 8'h26};
        8'h34: m = {2'b10, 8'h25};  8'h35: m = {2'b10, 8'h2E};
        8'h36: m = {2'b10, 8'h36};  8'h37: m = {2'b10, 8'h3D};
        8'h38: m = {2'b10, 8'h3E};  8'h39: m = {2'b10, 8'h46};
        // unshifted punctuation and control keys
        8'h60: m = {2'b10, 8'h0E};  8'h2D: m = {2'b10, 8'h4E};
        8'h3D: m = {2'b10, 8'h55};  8'h5B: m = {2'b10, 8'h54};
        8'h5D: m = {2'b10, 8'h5B};  8'h5C: m = {2'b10, 8'h5D};
        8'h3B: m = {2'b10, 8'h4C};  8'h27: m = {2'b10, 8'h52};
        8'h2C: m = {2'b10, 8'h41};  8'h2E: m = {2'b10, 8'h49};
        8'h2F: m = {2'b10, 8'h4A};  8'h20: m = {2'b10, 8'h29};
        8'h0D: m = {2'b10, 8'h5A};  8'h08: m = {2'b10, 8'h66};
        8'h09: m = {2'b10, 8'h0D};
        // shifted digit row
        8'h29: m = {2'b11, 8'h45};  8'h21: m = {2'b11, 8'h16};
        8'h40: m = {2'b11, 8'h1E};  8'h23: m = {2'b11, 8'h26};
        8'h24: m = {2'b11, 8'h25};  8'h25: m = {2'b11, 8'h2E};
        8'h5E: m = {2'b11, 8'h36};  8'h26: m = {2'b11, 8'h3D};
        8'h2A: m = {2'b11, 8'h3E};  8'h28: m = {2'b11, 8'h46};
        // shifted punctuation
        8'h7E: m = {2'b11, 8'h0E};  8'h5F: m = {2'b11, 8'h4E};
        8'h2B: m = {2'b11, 8'h55};  8'h7B: m = {2'b11, 8'h54};
        8'h7D: m = {2'b11, 8'h5B};  8'h7C: m = {2'b11, 8'h5D};
        8'h3A: m = {2'b11, 8'h4C};  8'h22: m = {2'b11, 8'h52};
        8'h3C: m = {2'b11, 8'h41};  8'h3E: m = {2'b11, 8'h49};
        8'h3F: m = {2'b11, 8'h4A};
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] key_q, key_d;
  logic       shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] gap_q, gap_d;
  logic       unsup_q, unsup_d;

  map_t       in_map;
  logic [2:0] last_idx;
  logic       seq_done;
  logic [7:0] byte_sel;

  // Both sequences index one 6-slot frame (Shift, K, F0, K, F0, Shift);
  // unshifted characters just use slots 1..3.
  assign in_map   = lookup(ascii_code);
  assign last_idx = shift_q ? 3'd5 : 3'd3;
  assign seq_done = (idx_q == last_idx + 3'd1);

  // Byte for the current frame slot
  always_comb begin
    byte_sel = 8'h00;
    case (idx_q)
      3'd0, 3'd5: byte_sel = SHIFT_CODE;
      3'd1, 3'd3: byte_sel = key_q;
      3'd2, 3'd4: byte_sel = BREAK_CODE;
      default:    byte_sel = 8'h00;
    endcase
  end

  // Next-state: accept in IDLE, step bytes on handshake, count gap cycles
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    unsup_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ascii_valid) begin
          if (in_map.sup) begin
            key_d   = in_map.key;
            shift_d = in_map.shift;
            idx_d   = in_map.shift ? 3'd0 : 3'd1;
            state_d = EMIT;
          end else begin
            unsup_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (scan_ready) begin
          idx_d = idx_q + 3'd1;
          if (GAP_CYCLES > 0) begin
            gap_d   = 8'd0;
            state_d = GAP;
          end else if (idx_q == last_idx) begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = seq_done ? IDLE : EMIT;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= 8'h00;
      shift_q <= 1'b0;
      idx_q   <= 3'd0;
      gap_q   <= 8'd0;
      unsup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      unsup_q <= unsup_d;
    end
  end

  assign ascii_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign scan_valid  = (state_q == EMIT);
  assign scan_code   = scan_valid ? byte_sel : 8'h00;
  assign scan_last   = scan_valid && (idx_q == last_idx);
  assign unsupported = unsup_q;

endmodule
